// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, operand-select encodings and FSM state type for alu_seq_unit.
package alu_seq_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_PASS = 4'b0001;
  localparam logic [OPC_W-1:0] OP_NEG  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_MUL  = 4'b0110;

  typedef enum logic [1:0] {
    A_SEL_A   = 2'b00,
    A_SEL_NEG = 2'b10
  } a_sel_e;

  typedef enum logic {
    B_SEL_B    = 1'b0,
    B_SEL_ZERO = 1'b1
  } b_sel_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_MUL_RUN = 2'b01,
    S_DONE    = 2'b10
  } state_e;

  typedef struct packed {
    b_sel_e b_sel;
    a_sel_e a_sel;
    logic   is_mul;
    logic   illegal;
  } dec_t;

endpackage

// File: rtl/alu_seq_unit_sel_decode.sv
// Combinational opcode decoder: operand-mux selects plus multiply and illegal-opcode flags.
module alu_sel_decode
  import alu_seq_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output dec_t           dec
);

  // Opcode constants are zero-extended so wider opcode fields still decode uniquely.
  always_comb begin
    dec = '{b_sel: B_SEL_ZERO, a_sel: A_SEL_A, is_mul: 1'b0, illegal: 1'b1};
    case (opcode)
      OPW'(OP_PASS): dec = '{b_sel: B_SEL_ZERO, a_sel: A_SEL_A,   is_mul: 1'b0, illegal: 1'b0};
      OPW'(OP_NEG):  dec = '{b_sel: B_SEL_ZERO, a_sel: A_SEL_NEG, is_mul: 1'b0, illegal: 1'b0};
      OPW'(OP_SUB):  dec = '{b_sel: B_SEL_B,    a_sel: A_SEL_NEG, is_mul: 1'b0, illegal: 1'b0};
      OPW'(OP_ADD):  dec = '{b_sel: B_SEL_B,    a_sel: A_SEL_A,   is_mul: 1'b0, illegal: 1'b0};
      OPW'(OP_MUL):  dec = '{b_sel: B_SEL_B,    a_sel: A_SEL_A,   is_mul: 1'b1, illegal: 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU: shared adder for single-cycle ops, iterative shift-add multiply,
// registered result and flags.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             illegal
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned PROD_W = 2 * WIDTH;

  state_e            state;
  state_e            state_nxt;
  dec_t              dec;
  logic              accept;
  logic              cnt_last;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  sum;
  logic              cin;
  logic              add_ovf;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] acc_nxt;
  logic [PROD_W-1:0] mcand;
  logic [WIDTH-1:0]  mplier;
  logic [CNT_W-1:0]  cnt;

  alu_sel_decode #(.OPW(OPW)) u_decode (
    .opcode (opcode),
    .dec    (dec)
  );

  // Shared adder: -A is formed as ~A plus a carry-in of one.
  assign op_a    = (dec.a_sel == A_SEL_NEG) ? ~a : a;
  assign cin     = (dec.a_sel == A_SEL_NEG);
  assign op_b    = (dec.b_sel == B_SEL_ZERO) ? '0 : b;
  assign sum     = op_a + op_b + WIDTH'(cin);
  assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);

  assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;
  assign cnt_last = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = dec.is_mul ? S_MUL_RUN : S_DONE;
      end
      S_MUL_RUN: begin
        if (cnt_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) state_nxt = dec.is_mul ? S_MUL_RUN : S_DONE;
          else          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // In DONE the slot frees as the consumer takes the result, allowing one op per cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE:  in_ready = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result  <= '0;
      zero    <= 1'b0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
      illegal <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else if (accept && dec.is_mul) begin
      acc    <= '0;
      mcand  <= PROD_W'(a);
      mplier <= b;
      cnt    <= '0;
    end else if (accept) begin
      result  <= dec.illegal ? '0 : sum;
      zero    <= dec.illegal || (sum == '0);
      neg     <= !dec.illegal && sum[WIDTH-1];
      ovf     <= !dec.illegal && add_ovf;
      illegal <= dec.illegal;
    end else if (state == S_MUL_RUN) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      // The final partial product is folded straight into the output registers.
      if (cnt_last) begin
        result  <= acc_nxt[WIDTH-1:0];
        zero    <= (acc_nxt[WIDTH-1:0] == '0);
        neg     <= acc_nxt[WIDTH-1];
        ovf     <= |acc_nxt[PROD_W-1:WIDTH];
        illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (WIDTH=8): directed corner cases plus randomized
// traffic scored against an arithmetic reference model.
module tb_alu_seq_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned OPW   = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             illegal;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  always #5 clock = ~clock;

  alu_seq_unit #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {result, zero, neg, ovf, illegal} from signed/unsigned integer arithmetic.
  function automatic logic [11:0] ref_model(input logic [3:0] op, input logic [7:0] x,
                                            input logic [7:0] y);
    int sa, sb, s, p;
    logic [7:0] r;
    logic v, ill;
    sa = int'($signed(x));
    sb = int'($signed(y));
    r = 8'd0; v = 1'b0; ill = 1'b0;
    case (op)
      4'b0001: r = x;
      4'b0010: begin s = -sa;     r = 8'(s); v = (s > 127); end
      4'b0011: begin s = sb - sa; r = 8'(s); v = (s > 127) || (s < -128); end
      4'b0100: begin s = sa + sb; r = 8'(s); v = (s > 127) || (s < -128); end
      4'b0110: begin p = int'(x) * int'(y); r = 8'(p); v = (p > 255); end
      default: ill = 1'b1;
    endcase
    return {r, (r == 8'd0), r[7], v, ill};
  endfunction

  // Scoreboard: transfers are sampled mid-cycle and complete on the next rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0)
          check("sb_out", 64'({result, zero, neg, ovf, illegal}), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(opcode, a, b));
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    bit ok;
    ok = 1'b0;
    opcode = op; a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clock);
      ok = in_ready;
      if (!ok) begin
        @(posedge clock); #1;
      end
    end
    check("accept_bound", 64'(ok), 64'(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int lat, input logic [7:0] r,
                            input logic z, input logic ng, input logic o, input logic il);
    int n;
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 64) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    check({tag, "_lat"}, 64'(n + 1), 64'(lat));
    check(tag, 64'({result, zero, neg, ovf, illegal}), 64'({r, z, ng, o, il}));
    @(posedge clock); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  stale;
    bit  acc;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; a = '0; b = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();

    @(negedge clock);
    check("reset_state", 64'({out_valid, in_ready, result, zero, neg, ovf, illegal}),
          64'({1'b0, 1'b1, 8'h00, 4'b0000}));
    @(posedge clock); #1;

    send(4'b0100, 8'h7F, 8'h01); expect_out("add_ovf", 1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    send(4'b0011, 8'h05, 8'h03); expect_out("sub",     1, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
    send(4'b0010, 8'h80, 8'h00); expect_out("neg_min", 1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    send(4'b0110, 8'd12, 8'd11); expect_out("mul_12x11", 9, 8'h84, 1'b0, 1'b1, 1'b0, 1'b0);
    send(4'b0110, 8'd16, 8'd16); expect_out("mul_16x16", 9, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    send(4'b0110, 8'd0, 8'd77);  expect_out("mul_zero",  9, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    send(4'b1111, 8'h12, 8'h34); expect_out("illegal",   1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    send(4'b0100, 8'h02, 8'h03); expect_out("add_clr",   1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back single-cycle ops with the consumer always ready.
    opcode = 4'b0100; a = 8'd1; b = 8'd2; in_valid = 1'b1;
    @(posedge clock); #1;
    opcode = 4'b0011; a = 8'd1; b = 8'd7;
    @(negedge clock); check("b2b_add",  64'({out_valid, in_ready, result}), 64'({2'b11, 8'd3}));
    @(posedge clock); #1;
    opcode = 4'b0001; a = 8'd9;
    @(negedge clock); check("b2b_sub",  64'({out_valid, in_ready, result}), 64'({2'b11, 8'd6}));
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock); check("b2b_pass", 64'({out_valid, result}), 64'({1'b1, 8'd9}));
    @(posedge clock); #1;
    @(negedge clock); check("b2b_idle", 64'(out_valid), 64'(0));
    @(posedge clock); #1;

    // Consumer stalls: result held and producer blocked.
    out_ready = 1'b0;
    send(4'b0100, 8'h10, 8'h20);
    opcode = 4'b0011; a = 8'd1; b = 8'd2; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("hold", 64'({out_valid, in_ready, result}), 64'({2'b10, 8'h30}));
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(negedge clock); check("hold_release", 64'(in_ready), 64'(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock); check("hold_next", 64'({out_valid, result}), 64'({1'b1, 8'd1}));
    @(posedge clock); #1;

    // Reset in the middle of a multiply discards it.
    send(4'b0110, 8'd12, 8'd11);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("mid_mul_reset", 64'({out_valid, in_ready, result, zero, neg, ovf, illegal}),
          64'({1'b0, 1'b1, 8'h00, 4'b0000}));
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      @(negedge clock);
      if (out_valid) stale++;
    end
    check("no_stale_out", 64'(stale), 64'(0));
    @(posedge clock); #1;

    // Randomized traffic; the producer holds an op until it is accepted.
    acc = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      acc = in_valid && in_ready;
      @(posedge clock); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        if ($urandom_range(0, 4) != 0) begin
          in_valid = 1'b1;
          case ($urandom_range(0, 6))
            0:       opcode = 4'b0001;
            1:       opcode = 4'b0010;
            2:       opcode = 4'b0011;
            3:       opcode = 4'b0100;
            4:       opcode = 4'b0110;
            5:       opcode = 4'($urandom_range(7, 15));
            default: opcode = ($urandom_range(0, 1) != 0) ? 4'b0000 : 4'b0101;
          endcase
          a = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
          b = ($urandom_range(0, 7) == 0) ? 8'h7F : 8'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end

    // Drain remaining results.
    @(negedge clock);
    acc = in_valid && in_ready;
    @(posedge clock); #1;
    if (!acc && in_valid) begin
      for (int i = 0; i < 64 && !acc; i++) begin
        @(negedge clock);
        acc = in_ready;
        @(posedge clock); #1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || out_valid); i++) begin
      @(posedge clock); #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
